// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data accesses.
// Data wins by default, but fetch is guaranteed a grant after STARVE_LIMIT data grants.
module mem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int TIMEOUT      = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall,
    output logic          err
);

    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SCW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t          r_state;
    logic [WCW-1:0]  r_wait_cnt;
    logic [SCW-1:0]  r_starve_cnt;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic [DW-1:0]   r_if_rdata;
    logic [DW-1:0]   r_d_rdata;
    logic            r_if_ack;
    logic            r_d_ack;
    logic            r_err;

    logic            w_starve_ok;
    logic            w_timeout;
    logic            w_done;
    logic [DW-1:0]   w_rdata;

    assign w_starve_ok = (r_starve_cnt < SCW'(STARVE_LIMIT));
    assign w_timeout   = (TIMEOUT != 0) && (r_wait_cnt == WCW'(TIMEOUT - 1)) && !mem_ack;
    assign w_done      = mem_ack || w_timeout;
    // A timed-out access returns zero rather than whatever is on the bus.
    assign w_rdata     = mem_ack ? mem_rdata : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_wait_cnt   <= '0;
            r_starve_cnt <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
            r_if_ack     <= 1'b0;
            r_d_ack      <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (d_req && (!if_req || w_starve_ok)) begin
                        r_state     <= BUSY_D;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= d_we;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_wait_cnt  <= '0;
                        // Grant condition already bounds the count, so this saturates.
                        if (if_req) begin
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                        end
                    end else if (if_req) begin
                        r_state      <= BUSY_IF;
                        r_mem_req    <= 1'b1;
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= if_addr;
                        r_mem_wdata  <= '0;
                        r_wait_cnt   <= '0;
                        r_starve_cnt <= '0;
                    end
                end
                BUSY_IF, BUSY_D: begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                    if (w_done) begin
                        r_state   <= RESP;
                        r_mem_req <= 1'b0;
                        if (w_timeout) begin
                            r_err <= 1'b1;
                        end
                        if (r_state == BUSY_D) begin
                            r_d_rdata <= w_rdata;
                            r_d_ack   <= 1'b1;
                        end else begin
                            r_if_rdata <= w_rdata;
                            r_if_ack   <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign if_ack    = r_if_ack;
    assign d_ack     = r_d_ack;
    assign err       = r_err;

    // Gated by reset so requesters held high during reset do not freeze the datapath.
    assign stall = reset & ((if_req & ~if_ack) | (d_req & ~d_ack));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a behavioural variable-latency memory.
// Inputs are driven and outputs sampled 1ns after the falling clock edge.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          stall;
    logic          err;

    int            checkCount = 0;
    int            passCount = 0;

    int            memLatency = 0;
    int            busyCnt = 0;
    logic          memAckModel = 1'b0;
    logic          forceAck = 1'b0;
    logic [DW-1:0] memRdata = '0;
    logic [DW-1:0] memArr [logic [AW-1:0]];

    mem_arbiter #(
        .AW(AW), .DW(DW), .TIMEOUT(16), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    assign mem_ack   = memAckModel | forceAck;
    assign mem_rdata = memRdata;

    // Memory acks on the busy cycle numbered memLatency (0 = first); negative never acks.
    always @(negedge clk) begin
        if (mem_req && memLatency >= 0 && busyCnt == memLatency) begin
            memAckModel = 1'b1;
            if (mem_we) memArr[mem_addr] = mem_wdata;
            memRdata = memArr.exists(mem_addr) ? memArr[mem_addr] : (mem_addr ^ 32'h5A5A_0000);
        end else begin
            memAckModel = 1'b0;
        end
        busyCnt = mem_req ? busyCnt + 1 : 0;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        else
            passCount++;
    endtask

    task automatic applyStimulus(input logic ifReq, input logic [AW-1:0] ifAddr,
                                 input logic dReq, input logic dWe,
                                 input logic [AW-1:0] dAddr, input logic [DW-1:0] dWdata);
        if_req  = ifReq;
        if_addr = ifAddr;
        d_req   = dReq;
        d_we    = dWe;
        d_addr  = dAddr;
        d_wdata = dWdata;
    endtask

    task automatic doReset();
        reset = 1'b0;
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);
        #1;
        checkOutput("reset_stall", stall, 0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic waitForAck(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (if_ack || d_ack) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    task automatic watchTxn(output int reqCycles, output int memAckTick,
                            output int ackTick, output bit stallDrop);
        reqCycles  = 0;
        memAckTick = -1;
        ackTick    = -1;
        stallDrop  = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (if_ack || d_ack) begin
                ackTick = i;
                return;
            end
            if (mem_req) reqCycles++;
            if (mem_ack) memAckTick = i;
            if (!stall) stallDrop = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;
        int reqCycles, memAckTick, ackTick;
        bit stallDrop;

        // Reset values
        reset = 1'b0;
        tick();
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_if_ack", if_ack, 0);
        checkOutput("rst_d_ack", d_ack, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        checkOutput("rst_if_rdata", if_rdata, 0);
        checkOutput("rst_d_rdata", d_rdata, 0);
        doReset();

        // Single zero-wait fetch
        memLatency = 0;
        memArr[32'h100] = 32'hE3A0_1005;
        tick();
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("fetch_stall_req", stall, 1);
        tick();
        checkOutput("fetch_mem_req", mem_req, 1);
        checkOutput("fetch_mem_addr", mem_addr, 32'h100);
        checkOutput("fetch_mem_we", mem_we, 0);
        tick();
        checkOutput("fetch_if_ack", if_ack, 1);
        checkOutput("fetch_if_rdata", if_rdata, 32'hE3A0_1005);
        checkOutput("fetch_stall_resp", stall, 0);
        checkOutput("fetch_mem_req_resp", mem_req, 0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("fetch_if_ack_pulse", if_ack, 0);

        // Store then load of the same address
        memLatency = 1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h2000, 32'hCAFE_F00D);
        tick();
        checkOutput("store_mem_we", mem_we, 1);
        checkOutput("store_mem_addr", mem_addr, 32'h2000);
        checkOutput("store_mem_wdata", mem_wdata, 32'hCAFE_F00D);
        waitForAck(seen);
        checkOutput("store_ack_seen", seen, 1);
        checkOutput("store_d_ack", d_ack, 1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h0);
        tick();
        checkOutput("load_mem_we", mem_we, 0);
        checkOutput("load_mem_addr", mem_addr, 32'h2000);
        waitForAck(seen);
        checkOutput("load_ack_seen", seen, 1);
        checkOutput("load_d_rdata", d_rdata, 32'hCAFE_F00D);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Contention: D,D,D,D,IF repeating
        doReset();
        memLatency = 0;
        tick();
        applyStimulus(1'b1, 32'h400, 1'b1, 1'b0, 32'h800, 32'h0);
        for (int i = 0; i < 20; i++) begin
            waitForAck(seen);
            checkOutput($sformatf("grant%0d", i), {d_ack, if_ack}, (i % 5 == 4) ? 2'b01 : 2'b10);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();

        // Five wait states
        memLatency = 5;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h0);
        watchTxn(reqCycles, memAckTick, ackTick, stallDrop);
        checkOutput("wait_req_cycles", reqCycles, 6);
        checkOutput("wait_mem_ack_tick", memAckTick, 6);
        checkOutput("wait_ack_tick", ackTick, 7);
        checkOutput("wait_stall_held", stallDrop, 0);
        checkOutput("wait_d_rdata", d_rdata, 32'hCAFE_F00D);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("wait_d_ack_pulse", d_ack, 0);

        // Timeout zeroes read data and sets sticky err
        doReset();
        memLatency = 0;
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h3004, 32'h0);
        waitForAck(seen);
        checkOutput("pre_to_d_rdata", d_rdata, 32'h5A5A_3004);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        memLatency = -1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h3008, 32'h0);
        watchTxn(reqCycles, memAckTick, ackTick, stallDrop);
        checkOutput("to_req_cycles", reqCycles, 16);
        checkOutput("to_ack_tick", ackTick, 17);
        checkOutput("to_d_ack", d_ack, 1);
        checkOutput("to_d_rdata", d_rdata, 0);
        checkOutput("to_err", err, 1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        checkOutput("to_err_sticky", err, 1);

        // Stray mem_ack while idle is ignored
        forceAck = 1'b1;
        tick();
        forceAck = 1'b0;
        tick();
        checkOutput("stray_ack_ignored", {if_ack, d_ack, mem_req}, 3'b000);

        // Async reset in the middle of a data access
        memLatency = -1;
        applyStimulus(1'b1, 32'h500, 1'b1, 1'b0, 32'h3010, 32'h0);
        tick();
        tick();
        checkOutput("ar_busy_mem_req", mem_req, 1);
        checkOutput("ar_busy_mem_addr", mem_addr, 32'h3010);
        reset = 1'b0;
        #1;
        checkOutput("ar_mem_req", mem_req, 0);
        checkOutput("ar_err", err, 0);
        checkOutput("ar_stall", stall, 0);
        checkOutput("ar_mem_addr", mem_addr, 0);
        applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        memLatency = 0;
        memArr[32'h500] = 32'h1234_5678;
        reset = 1'b1;
        tick();
        checkOutput("ar_fetch_mem_req", mem_req, 1);
        checkOutput("ar_fetch_mem_addr", mem_addr, 32'h500);
        tick();
        checkOutput("ar_fetch_if_ack", if_ack, 1);
        checkOutput("ar_fetch_if_rdata", if_rdata, 32'h1234_5678);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
